rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port 0 is the ALU result and port 1 is the memory load data.
- Arbitrates round-robin over a valid/ready handshake and registers the winning write for one cycle.
- Drives write enable, a 5-bit address and a 32-bit one-hot word select into the register file, where the 5x32 decoder selects the row.
- Sits between the execute/memory stages and the register file in the processor datapath.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU write request.
- req0_addr  in  ADDR_WIDTH  ALU destination register.
- req0_data  in  DATA_WIDTH  ALU write data.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load write request.
- req1_addr  in  ADDR_WIDTH  load destination register.
- req1_data  in  DATA_WIDTH  load write data.
- req1_ready  out  1  load request accepted this cycle.
- rf_stall  in  1  register file cannot complete a write this cycle.
- rf_we  out  1  register file write enable.
- rf_addr  out  ADDR_WIDTH  write address.
- rf_data  out  DATA_WIDTH  write data.
- rf_wsel  out  NUM_REGS  one-hot decode of rf_addr, gated by rf_we.
- busy  out  1  a write is in the output stage.

Behaviour:
- Reset (RST low, takes effect immediately, asynchronous):
  - rf_we=0, rf_addr=0, rf_data=0, rf_wsel=0, busy=0.
  - State=IDLE, round-robin pointer favours port 0.
  - An accepted write not yet committed is discarded.
  - req*_ready are 0 while RST is low.
- Handshake:
  - A transfer occurs on the rising edge where reqN_valid and reqN_ready are both 1.
  - readyN is combinational from the valids, the pointer, the state and rf_stall.
  - A requester must hold valid, addr and data stable until it is accepted.
- Arbitration:
  - If only one port is valid, it is granted.
  - If both are valid, the port named by the pointer is granted.
  - After every transfer, the pointer moves to the other port.
  - At most one readyN is high per cycle.
- FSM states: IDLE and WR.
  - IDLE: ready is granted to the winner. A transfer moves to WR; the output regs load addr and data, rf_we=1.
  - WR, rf_stall=0: the write commits this cycle. If a new transfer occurs in the same cycle, stay in WR and load the new write (back-to-back, one write per cycle). Otherwise go to IDLE with rf_we=0.
  - WR, rf_stall=1: both readies are 0, all rf_* outputs are held unchanged, and the state stays WR.
- Latency: a transfer at edge N gives rf_we=1 during cycle N+1. Throughput is one write per cycle with no stall.
- Register 0 is hardwired to zero:
  - A request with addr=0 still completes its handshake and advances the pointer.
  - It produces no write: state stays or returns IDLE, rf_we=0.
- rf_wsel equals 1<<rf_addr when rf_we=1, and 0 otherwise.
- busy equals (state==WR).
- Same-address simultaneous requests: one is granted per the pointer, and the other is written in the following cycle. The later write wins in the register file.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- When defined, the block adds these ports:
  - byp_addr  in  ADDR_WIDTH.
  - byp_hit  out  1.
  - byp_data  out  DATA_WIDTH.
- byp_hit = rf_we && (rf_addr == byp_addr) && (byp_addr != 0), combinational.
- byp_data = rf_data when byp_hit is 1, else 0.
- This forwards the in-flight write to a same-cycle register read.
- When the macro is not defined, the ports and logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package or definitions file holds:
  - the state encodings for IDLE and WR,
  - DATA_WIDTH, ADDR_WIDTH and NUM_REGS defaults,
  - the zero-register address constant.
- One sub-module, rr_arbiter_2: a 2-input round-robin grant with a pointer register, a valids input and a one-hot grant output.
- The one-hot rf_wsel is built from the existing 5x32 decoder instance, gated by rf_we.

Test Plan:
- Reset with both valid → readies 0 and rf_* 0. Release RST with only req0 (addr=3, data=0xA5A5A5A5) → req0_ready=1. Next cycle rf_we=1, rf_addr=3, rf_wsel=0x00000008.
- Both valid every cycle (req0 addr=1, req1 addr=2) → grants alternate 0,1,0,1. rf_addr sequence is 1,2,1,2 on consecutive cycles.
- rf_stall=1 for 3 cycles during WR (rf_addr=7, data=0x12345678) → outputs held, both readies 0. The write commits on the cycle stall drops.
- req1 addr=0, data=0xFFFFFFFF → req1_ready=1, rf_we stays 0, rf_wsel=0. The pointer still advances.
- Assert RST low mid-WR (rf_addr=9) → rf_we=0 immediately. After release, the first simultaneous request grants port 0.
- With RF_WRITE_BYPASS_EN: byp_addr=5 while rf_addr=5 is being written with 0xDEADBEEF → byp_hit=1, byp_data=0xDEADBEEF. With byp_addr=0 → byp_hit=0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: defaults, FSM encoding, zero register.
package rf_write_arbiter_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 5;
    localparam int unsigned DefaultNumRegs   = 32;

    // Writes to this register are accepted but dropped.
    localparam int unsigned ZeroRegAddr = 0;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWr   = 1'b1
    } state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request ports and register-file write port of the write arbiter.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned NUM_REGS   = DefaultNumRegs
) ();

    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  rf_stall;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;
    logic [NUM_REGS-1:0]   rf_wsel;
    logic                  busy;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  rf_stall,
        output rf_we, rf_addr, rf_data, rf_wsel, busy
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output rf_stall,
        input  rf_we, rf_addr, rf_data, rf_wsel, busy
    );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant; the pointer flips to the other port after each transfer.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // A port-0 transfer hands priority to port 1 and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = grant[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, one write per cycle.
// Optional same-cycle read forwarding is enabled with RF_WRITE_BYPASS_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned NUM_REGS   = DefaultNumRegs
) (
    input  logic                  CLK,
    input  logic                  RST,
    rf_write_arbiter_if.slave     bus
`ifdef RF_WRITE_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0] byp_addr,
    output logic                  byp_hit,
    output logic [DATA_WIDTH-1:0] byp_data
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            valid, grant, ready;
    logic                  can_accept, transfer, write_new, rf_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    assign valid = {bus.req1_valid, bus.req0_valid};

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk     (CLK),
        .rst_n   (RST),
        .valid   (valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign transfer  = |ready;
    assign win_addr  = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign win_data  = grant[1] ? bus.req1_data : bus.req0_data;
    assign write_new = transfer && (win_addr != ADDR_WIDTH'(ZeroRegAddr));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (write_new) state_d = StWr;
            StWr:   if (!bus.rf_stall) state_d = write_new ? StWr : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A stalled write blocks new grants so the output stage holds still.
    always_comb begin
        can_accept = (state_q == StIdle) || !bus.rf_stall;
        ready      = (RST && can_accept) ? grant : 2'b00;
        rf_we      = (state_q == StWr);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (write_new) begin
            addr_q <= win_addr;
            data_q <= win_data;
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.rf_we      = rf_we;
    assign bus.rf_addr    = addr_q;
    assign bus.rf_data    = data_q;
    // Row decode of the write address, gated so idle cycles select no row.
    assign bus.rf_wsel    = rf_we ? (NUM_REGS'(1) << addr_q) : '0;
    assign bus.busy       = rf_we;

`ifdef RF_WRITE_BYPASS_EN
    assign byp_hit  = rf_we && (addr_q == byp_addr) && (byp_addr != ADDR_WIDTH'(ZeroRegAddr));
    assign byp_data = byp_hit ? data_q : '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

`ifdef RF_WRITE_BYPASS_EN
    logic [4:0]  byp_addr = '0;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    rf_write_arbiter dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus)
`ifdef RF_WRITE_BYPASS_EN
        ,
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic set_req(input int port, input logic v, input logic [4:0] a,
                           input logic [31:0] d);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
        end
    endtask

    initial begin
        bus.rf_stall = 1'b0;
        set_req(0, 1'b1, 5'd3, 32'hA5A5_A5A5);
        set_req(1, 1'b1, 5'd4, 32'h4444_4444);

        // Reset held with both requesters valid.
        @(negedge clk);
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_ready1", 64'(bus.req1_ready), 64'd0);
        check("rst_we", 64'(bus.rf_we), 64'd0);
        check("rst_addr", 64'(bus.rf_addr), 64'd0);
        check("rst_data", 64'(bus.rf_data), 64'd0);
        check("rst_wsel", 64'(bus.rf_wsel), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // Single ALU write to r3.
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t1_ready0", 64'(bus.req0_ready), 64'd1);
        check("t1_ready1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t1_we", 64'(bus.rf_we), 64'd1);
        check("t1_addr", 64'(bus.rf_addr), 64'd3);
        check("t1_data", 64'(bus.rf_data), 64'hA5A5_A5A5);
        check("t1_wsel", 64'(bus.rf_wsel), 64'h0000_0008);
        check("t1_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("t1_idle_we", 64'(bus.rf_we), 64'd0);
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Load to r0: handshake completes, nothing is written.
        set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("t4_ready1", 64'(bus.req1_ready), 64'd1);
        check("t4_ready0", 64'(bus.req0_ready), 64'd0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t4_we", 64'(bus.rf_we), 64'd0);
        check("t4_wsel", 64'(bus.rf_wsel), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd0);

        // Both valid every cycle: grants alternate starting at port 0.
        set_req(0, 1'b1, 5'd1, 32'h1111_1111);
        set_req(1, 1'b1, 5'd2, 32'h2222_2222);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            else #1;
            check("t2_ready0", 64'(bus.req0_ready), 64'((k % 2) == 0));
            check("t2_ready1", 64'(bus.req1_ready), 64'((k % 2) == 1));
            if (k > 0) begin
                check("t2_we", 64'(bus.rf_we), 64'd1);
                check("t2_addr", 64'(bus.rf_addr), ((k % 2) == 1) ? 64'd1 : 64'd2);
            end
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t2_last_addr", 64'(bus.rf_addr), 64'd2);
        check("t2_last_data", 64'(bus.rf_data), 64'h2222_2222);

        // Stall for three cycles with a write to r7 in the output stage.
        set_req(0, 1'b1, 5'd7, 32'h1234_5678);
        #1;
        check("t3_ready0", 64'(bus.req0_ready), 64'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        set_req(1, 1'b1, 5'd8, 32'h8888_8888);
        bus.rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_we", 64'(bus.rf_we), 64'd1);
            check("t3_stall_addr", 64'(bus.rf_addr), 64'd7);
            check("t3_stall_data", 64'(bus.rf_data), 64'h1234_5678);
            check("t3_stall_wsel", 64'(bus.rf_wsel), 64'h0000_0080);
            check("t3_stall_ready0", 64'(bus.req0_ready), 64'd0);
            check("t3_stall_ready1", 64'(bus.req1_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.rf_stall = 1'b0;
        @(negedge clk);
        check("t3_commit_we", 64'(bus.rf_we), 64'd1);
        check("t3_commit_addr", 64'(bus.rf_addr), 64'd7);
        check("t3_b2b_ready1", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t3_next_addr", 64'(bus.rf_addr), 64'd8);
        check("t3_next_data", 64'(bus.rf_data), 64'h8888_8888);

        // Reset in the middle of a write to r9; pointer must return to port 0.
        set_req(0, 1'b1, 5'd9, 32'h9999_9999);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t5_we_before", 64'(bus.rf_we), 64'd1);
        check("t5_addr_before", 64'(bus.rf_addr), 64'd9);
        set_req(0, 1'b1, 5'd10, 32'hA0A0_A0A0);
        set_req(1, 1'b1, 5'd11, 32'hB0B0_B0B0);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_we", 64'(bus.rf_we), 64'd0);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_addr", 64'(bus.rf_addr), 64'd0);
        check("t5_rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("t5_rst_ready1", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_ptr_ready0", 64'(bus.req0_ready), 64'd1);
        check("t5_ptr_ready1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t5_after_addr", 64'(bus.rf_addr), 64'd10);

`ifdef RF_WRITE_BYPASS_EN
        // Forwarding of the in-flight write.
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        byp_addr = 5'd5;
        #1;
        check("byp_hit", 64'(byp_hit), 64'd1);
        check("byp_data", 64'(byp_data), 64'hDEAD_BEEF);
        byp_addr = 5'd0;
        #1;
        check("byp_zero_hit", 64'(byp_hit), 64'd0);
        check("byp_zero_data", 64'(byp_data), 64'd0);
        byp_addr = 5'd6;
        #1;
        check("byp_miss_hit", 64'(byp_hit), 64'd0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
